sh7604_intc_periph: RTL
=======================

Name: sh7604_intc_periph

Overview:
- On-chip peripheral interrupt arbiter for the SH7604 model. Sits directly downstream of the FRT, SCI, WDT/BSC, DIVU and DMAC IRQ outputs.
- Holds the IPRA/IPRB priority registers and the VCRA/B/C/D/WDT vector registers on the internal bus.
- Resolves the highest-priority pending source every CE_R cycle and presents level+vector to the CPU core.
- On acknowledge it latches the vector so it stays stable for the exception fetch.

Parameters:
- VEC_W, 8, width of vector output (7-bit register fields zero-extended).

Ports:
- CLK  in  1  clock
- RST_N  in  1  async reset, active-low
- CE_R  in  1  rising-phase clock enable (state update)
- CE_F  in  1  falling-phase clock enable (bus read data)
- EN  in  1  block enable; when low, state holds
- RES_N  in  1  synchronous chip reset, active-low, sampled on CE_R
- IBUS_A  in  32  internal bus address
- IBUS_DI  in  32  write data, big-endian lanes
- IBUS_DO  out  32  read data; 0 when not selected
- IBUS_BA  in  4  byte lane enables (BA[3]=DI[31:24])
- IBUS_WE  in  1  write strobe
- IBUS_REQ  in  1  access request
- IBUS_BUSY  out  1  always 0
- IBUS_ACT  out  1  address decodes to this block
- DIVU_IRQ, DMA0_IRQ, DMA1_IRQ, WDT_ITI, BSC_CMI  in  1 each  source requests
- SCI_ERI, SCI_RXI, SCI_TXI, SCI_TEI  in  1 each  SCI requests
- FRT_ICI, FRT_OCIA, FRT_OCIB, FRT_OVI  in  1 each  FRT requests
- DIVU_VEC  in  7  DIVU vector (from VCRDIV)
- DMA0_VEC, DMA1_VEC  in  8 each  DMAC vectors (from VCRDMA0/1)
- INT_REQ  out  1  a source with nonzero level is pending
- INT_LVL  out  4  level of winning source
- INT_VEC  out  8  vector of winning source
- INT_ACK  in  1  CPU acknowledge, single CE_R pulse
- ACK_VEC  out  8  vector latched at last INT_ACK

Behaviour:
- Reset (RST_N low or RES_N low on CE_R): all registers 0; INT_REQ=0, INT_LVL=0, INT_VEC=0, ACK_VEC=0; REG_DO=0.
- Register map (16-bit words):
  - FFFFFE60 IPRB: SCI[15:12], FRT[11:8].
  - FE62 VCRA: ERI[14:8], RXI[6:0].
  - FE64 VCRB: TXI[14:8], TEI[6:0].
  - FE66 VCRC: ICI[14:8], OCI[6:0].
  - FE68 VCRD: OVI[14:8].
  - FFFFFEE2 IPRA: DIVU[15:12], DMAC[11:8], WDT[7:4].
  - FEE4 VCRWDT: ITI[14:8], CMI[6:0].
  - Unlisted bits: read 0, write ignored.
- Bus lanes: A[1]=0 uses DI[31:16]/BA[3:2]; A[1]=1 uses DI[15:0]/BA[1:0]. Byte writes update only the enabled byte.
- Writes commit on CE_R. Reads register on CE_F into REG_DO; IBUS_DO replicates the 16-bit word on both halves. No wait states.
- Arbitration runs every CE_R while EN. A source competes only if its request is high AND its level is nonzero; level 0 = masked.
  - Highest level wins.
  - Equal level, fixed order: DIVU > DMA0 > DMA1 > WDT_ITI > BSC_CMI > ERI > RXI > TXI > TEI > ICI > OCIA > OCIB > OVI.
  - OCIA and OCIB share the OCI vector.
- Winner is registered in one stage: INT_REQ/INT_LVL/INT_VEC reflect request inputs sampled one CE_R earlier. No winner: all three are 0.
- IPR/VCR write on the same edge as arbitration: the old value is used that cycle, the new value from the next cycle.
- INT_ACK on CE_R: ACK_VEC <= INT_VEC (the registered value). ACK_VEC then holds until the next INT_ACK, regardless of source deassertion. INT_ACK while INT_REQ=0 latches 0.
- Source flags are cleared by their owning modules; this block keeps no per-source pending state (level-sensitive).
- Reset mid-arbitration: next CE_R returns all outputs to 0.

Optional Feature:
- Macro INTC_ACK_SRC_EN.
- Defined: adds output ACK_SRC[3:0], the index (0=DIVU..12=OVI, order as above) of the source latched at INT_ACK; 4'hF when none. It is latched alongside ACK_VEC.
- Undefined: port and its register absent; behaviour otherwise identical.

Decomposition:
- Package SH7604_PKG gains:
  - IPRA_t, IPRB_t, VCRA_t, VCRB_t, VCRC_t, VCRD_t, VCRWDT_t packed structs.
  - *_INIT (all 0), *_WMASK and *_RMASK constants.
  - INTC_SRC_e enum giving the fixed order.
- Sub-module sh7604_intc_prio_enc: combinational 13-input level/vector comparator tree returning winning level, vector and index. The top module does registers, bus and the pipeline stage.

Test Plan:
- IPRB=0x0500, VCRC=0x4142, pulse FRT_OCIA high -> one CE_R later INT_REQ=1, INT_LVL=5, INT_VEC=0x42; drop OCIA -> next cycle INT_REQ=0.
- IPRA=0x5000, DIVU_VEC=0x33, IPRB=0x0500, assert DIVU_IRQ and FRT_ICI together -> INT_VEC=0x33 (tie order). Then IPRB=0x0600 -> INT_LVL=6, INT_VEC=VCRC.ICI.
- IPRB=0x0000 with all FRT/SCI requests high -> INT_REQ=0, INT_LVL=0, INT_VEC=0.
- INT_ACK with INT_VEC=0x42, then deassert source and change VCRC -> ACK_VEC stays 0x42 (ACK_SRC=10 with INTC_ACK_SRC_EN).
- Byte write BA=4'b0010 at FE62 with DI[15:8]=0x7F -> read FE62 returns 0x7F00 (bit 15 masked). Read FE60 shows IPRB unchanged.
- Assert RES_N low mid-request -> next CE_R all registers, INT_* and ACK_VEC = 0.

Source files
------------

// File: rtl/sh7604_intc_periph_pkg.sv
// ----------------------------------------------------------------------------
// sh7604_intc_periph_pkg
// Shared types and constants for the SH7604 on-chip peripheral interrupt
// controller: register layouts (IPRA/IPRB, VCRA..VCRD, VCRWDT), their reset,
// write and read masks, register addresses, and the fixed source order used
// to break ties between equal priority levels.
// No ports (package).
// ----------------------------------------------------------------------------
package sh7604_intc_periph_pkg;

    localparam int NUM_SRC = 13;

    typedef struct packed {
        logic [3:0] divu;
        logic [3:0] dmac;
        logic [3:0] wdt;
        logic [3:0] rsv;
    } IPRA_t;

    typedef struct packed {
        logic [3:0] sci;
        logic [3:0] frt;
        logic [7:0] rsv;
    } IPRB_t;

    typedef struct packed {
        logic       rsv1;
        logic [6:0] eri;
        logic       rsv0;
        logic [6:0] rxi;
    } VCRA_t;

    typedef struct packed {
        logic       rsv1;
        logic [6:0] txi;
        logic       rsv0;
        logic [6:0] tei;
    } VCRB_t;

    typedef struct packed {
        logic       rsv1;
        logic [6:0] ici;
        logic       rsv0;
        logic [6:0] oci;
    } VCRC_t;

    typedef struct packed {
        logic       rsv1;
        logic [6:0] ovi;
        logic [7:0] rsv0;
    } VCRD_t;

    typedef struct packed {
        logic       rsv1;
        logic [6:0] iti;
        logic       rsv0;
        logic [6:0] cmi;
    } VCRWDT_t;

    localparam IPRA_t   IPRA_INIT   = '0;
    localparam IPRB_t   IPRB_INIT   = '0;
    localparam VCRA_t   VCRA_INIT   = '0;
    localparam VCRB_t   VCRB_INIT   = '0;
    localparam VCRC_t   VCRC_INIT   = '0;
    localparam VCRD_t   VCRD_INIT   = '0;
    localparam VCRWDT_t VCRWDT_INIT = '0;

    localparam logic [15:0] IPRA_WMASK   = 16'hFFF0;
    localparam logic [15:0] IPRB_WMASK   = 16'hFF00;
    localparam logic [15:0] VCRA_WMASK   = 16'h7F7F;
    localparam logic [15:0] VCRB_WMASK   = 16'h7F7F;
    localparam logic [15:0] VCRC_WMASK   = 16'h7F7F;
    localparam logic [15:0] VCRD_WMASK   = 16'h7F00;
    localparam logic [15:0] VCRWDT_WMASK = 16'h7F7F;

    localparam logic [15:0] IPRA_RMASK   = 16'hFFF0;
    localparam logic [15:0] IPRB_RMASK   = 16'hFF00;
    localparam logic [15:0] VCRA_RMASK   = 16'h7F7F;
    localparam logic [15:0] VCRB_RMASK   = 16'h7F7F;
    localparam logic [15:0] VCRC_RMASK   = 16'h7F7F;
    localparam logic [15:0] VCRD_RMASK   = 16'h7F00;
    localparam logic [15:0] VCRWDT_RMASK = 16'h7F7F;

    localparam logic [31:0] ADDR_IPRB   = 32'hFFFF_FE60;
    localparam logic [31:0] ADDR_VCRA   = 32'hFFFF_FE62;
    localparam logic [31:0] ADDR_VCRB   = 32'hFFFF_FE64;
    localparam logic [31:0] ADDR_VCRC   = 32'hFFFF_FE66;
    localparam logic [31:0] ADDR_VCRD   = 32'hFFFF_FE68;
    localparam logic [31:0] ADDR_IPRA   = 32'hFFFF_FEE2;
    localparam logic [31:0] ADDR_VCRWDT = 32'hFFFF_FEE4;

    // Index order doubles as tie-break order: lower index wins.
    typedef enum logic [3:0] {
        SRC_DIVU = 4'd0,
        SRC_DMA0 = 4'd1,
        SRC_DMA1 = 4'd2,
        SRC_ITI  = 4'd3,
        SRC_CMI  = 4'd4,
        SRC_ERI  = 4'd5,
        SRC_RXI  = 4'd6,
        SRC_TXI  = 4'd7,
        SRC_TEI  = 4'd8,
        SRC_ICI  = 4'd9,
        SRC_OCIA = 4'd10,
        SRC_OCIB = 4'd11,
        SRC_OVI  = 4'd12,
        SRC_NONE = 4'hF
    } INTC_SRC_e;

    // Byte-lane merge of a 16-bit register write; be[1] selects the high byte.
    function automatic logic [15:0] wr_merge(input logic [15:0] old_v,
                                             input logic [15:0] data,
                                             input logic [1:0]  be,
                                             input logic [15:0] wmask);
        logic [15:0] m;
        m[15:8] = be[1] ? data[15:8] : old_v[15:8];
        m[7:0]  = be[0] ? data[7:0]  : old_v[7:0];
        return m & wmask;
    endfunction

endpackage

// File: rtl/sh7604_intc_periph_if.sv
// ----------------------------------------------------------------------------
// sh7604_intc_periph_if
// Internal bus bundle between the CPU-side bus master and the INTC registers.
//   A[31:0]   address            DI[31:0]  write data (big-endian lanes)
//   BA[3:0]   byte enables       WE        write strobe
//   REQ       access request     DO[31:0]  read data (slave drives)
//   BUSY      wait request       ACT       address decodes to slave
// Modports: master (bus owner), slave (this peripheral).
// ----------------------------------------------------------------------------
interface sh7604_intc_periph_if;
    logic [31:0] A;
    logic [31:0] DI;
    logic [31:0] DO;
    logic [3:0]  BA;
    logic        WE;
    logic        REQ;
    logic        BUSY;
    logic        ACT;

    modport master (output A, DI, BA, WE, REQ, input DO, BUSY, ACT);
    modport slave  (input A, DI, BA, WE, REQ, output DO, BUSY, ACT);
endinterface

// File: rtl/sh7604_intc_prio_enc.sv
// ----------------------------------------------------------------------------
// sh7604_intc_prio_enc
// Combinational priority resolver over the 13 peripheral sources.
//   req_i  per-source request      lvl_i  per-source level (0 = masked)
//   vec_i  per-source vector       lvl_o  winning level (0 when none)
//   vec_o  winning vector          idx_o  winning source index (4'hF none)
// ----------------------------------------------------------------------------
module sh7604_intc_prio_enc
    import sh7604_intc_periph_pkg::*;
#(
    parameter int VEC_W = 8
) (
    input  logic [NUM_SRC-1:0]            req_i,
    input  logic [NUM_SRC-1:0][3:0]       lvl_i,
    input  logic [NUM_SRC-1:0][VEC_W-1:0] vec_i,
    output logic [3:0]                    lvl_o,
    output logic [VEC_W-1:0]              vec_o,
    output logic [3:0]                    idx_o
);

    // Strict '>' keeps the earliest (highest-priority) source on a tie and
    // rejects level 0, so masked sources never win.
    always_comb begin
        lvl_o = '0;
        vec_o = '0;
        idx_o = SRC_NONE;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (req_i[i] && (lvl_i[i] > lvl_o)) begin
                lvl_o = lvl_i[i];
                vec_o = vec_i[i];
                idx_o = 4'(i);
            end
        end
    end

endmodule

// File: rtl/sh7604_intc_periph.sv
// ----------------------------------------------------------------------------
// sh7604_intc_periph
// SH7604 on-chip peripheral interrupt arbiter: IPRA/IPRB priority and
// VCRA/B/C/D/WDT vector registers on the internal bus, one registered
// arbitration stage towards the CPU, and a vector latch on acknowledge.
// Ports:
//   CLK, RST_N (async, active-low), CE_R/CE_F clock-enable phases, EN, RES_N
//   IBUS            internal bus slave (sh7604_intc_periph_if.slave)
//   *_IRQ/*_I*      level-sensitive source requests
//   DIVU_VEC, DMA0_VEC, DMA1_VEC   externally held vectors
//   INT_REQ/INT_LVL/INT_VEC        registered winner, INT_ACK, ACK_VEC
// Build option: define INTC_ACK_SRC_EN to add ACK_SRC[3:0], the index of
// the source latched at acknowledge.
// ----------------------------------------------------------------------------
module sh7604_intc_periph
    import sh7604_intc_periph_pkg::*;
#(
    parameter int VEC_W = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CE_R,
    input  logic             CE_F,
    input  logic             EN,
    input  logic             RES_N,
    sh7604_intc_periph_if.slave IBUS,
    input  logic             DIVU_IRQ,
    input  logic             DMA0_IRQ,
    input  logic             DMA1_IRQ,
    input  logic             WDT_ITI,
    input  logic             BSC_CMI,
    input  logic             SCI_ERI,
    input  logic             SCI_RXI,
    input  logic             SCI_TXI,
    input  logic             SCI_TEI,
    input  logic             FRT_ICI,
    input  logic             FRT_OCIA,
    input  logic             FRT_OCIB,
    input  logic             FRT_OVI,
    input  logic [6:0]       DIVU_VEC,
    input  logic [7:0]       DMA0_VEC,
    input  logic [7:0]       DMA1_VEC,
    output logic             INT_REQ,
    output logic [3:0]       INT_LVL,
    output logic [VEC_W-1:0] INT_VEC,
    input  logic             INT_ACK,
    output logic [VEC_W-1:0] ACK_VEC
`ifdef INTC_ACK_SRC_EN
    ,
    output logic [3:0]       ACK_SRC
`endif
);

    IPRA_t   ipra_q,   ipra_d;
    IPRB_t   iprb_q,   iprb_d;
    VCRA_t   vcra_q,   vcra_d;
    VCRB_t   vcrb_q,   vcrb_d;
    VCRC_t   vcrc_q,   vcrc_d;
    VCRD_t   vcrd_q,   vcrd_d;
    VCRWDT_t vcrwdt_q, vcrwdt_d;

    logic             int_req_q;
    logic [3:0]       int_lvl_q;
    logic [VEC_W-1:0] int_vec_q;
    logic [VEC_W-1:0] ack_vec_q;
    logic [15:0]      reg_do_q;

    // Bus decode: A[1] selects which 16-bit half of the 32-bit bus is live.
    logic [15:0] wdata;
    logic [1:0]  wbe;
    logic        sel_ipra, sel_iprb, sel_vcra, sel_vcrb, sel_vcrc, sel_vcrd, sel_vcrwdt;
    logic        hit, wr_en;
    logic [15:0] rdata;
    logic        unused_a0;

    assign wdata      = IBUS.A[1] ? IBUS.DI[15:0] : IBUS.DI[31:16];
    assign wbe        = IBUS.A[1] ? IBUS.BA[1:0]  : IBUS.BA[3:2];
    assign sel_iprb   = (IBUS.A[31:1] == ADDR_IPRB[31:1]);
    assign sel_vcra   = (IBUS.A[31:1] == ADDR_VCRA[31:1]);
    assign sel_vcrb   = (IBUS.A[31:1] == ADDR_VCRB[31:1]);
    assign sel_vcrc   = (IBUS.A[31:1] == ADDR_VCRC[31:1]);
    assign sel_vcrd   = (IBUS.A[31:1] == ADDR_VCRD[31:1]);
    assign sel_ipra   = (IBUS.A[31:1] == ADDR_IPRA[31:1]);
    assign sel_vcrwdt = (IBUS.A[31:1] == ADDR_VCRWDT[31:1]);
    assign hit        = sel_ipra | sel_iprb | sel_vcra | sel_vcrb | sel_vcrc | sel_vcrd | sel_vcrwdt;
    assign wr_en      = CE_R & EN & IBUS.REQ & IBUS.WE;
    assign unused_a0  = IBUS.A[0];

    assign IBUS.ACT  = hit;
    assign IBUS.BUSY = 1'b0;
    assign IBUS.DO   = {reg_do_q, reg_do_q};

    always_comb begin
        ipra_d   = ipra_q;
        iprb_d   = iprb_q;
        vcra_d   = vcra_q;
        vcrb_d   = vcrb_q;
        vcrc_d   = vcrc_q;
        vcrd_d   = vcrd_q;
        vcrwdt_d = vcrwdt_q;
        if (wr_en) begin
            if (sel_ipra)   ipra_d   = IPRA_t'(wr_merge(ipra_q, wdata, wbe, IPRA_WMASK));
            if (sel_iprb)   iprb_d   = IPRB_t'(wr_merge(iprb_q, wdata, wbe, IPRB_WMASK));
            if (sel_vcra)   vcra_d   = VCRA_t'(wr_merge(vcra_q, wdata, wbe, VCRA_WMASK));
            if (sel_vcrb)   vcrb_d   = VCRB_t'(wr_merge(vcrb_q, wdata, wbe, VCRB_WMASK));
            if (sel_vcrc)   vcrc_d   = VCRC_t'(wr_merge(vcrc_q, wdata, wbe, VCRC_WMASK));
            if (sel_vcrd)   vcrd_d   = VCRD_t'(wr_merge(vcrd_q, wdata, wbe, VCRD_WMASK));
            if (sel_vcrwdt) vcrwdt_d = VCRWDT_t'(wr_merge(vcrwdt_q, wdata, wbe, VCRWDT_WMASK));
        end
    end

    always_comb begin
        rdata = '0;
        if (sel_ipra)   rdata = ipra_q   & IPRA_RMASK;
        if (sel_iprb)   rdata = iprb_q   & IPRB_RMASK;
        if (sel_vcra)   rdata = vcra_q   & VCRA_RMASK;
        if (sel_vcrb)   rdata = vcrb_q   & VCRB_RMASK;
        if (sel_vcrc)   rdata = vcrc_q   & VCRC_RMASK;
        if (sel_vcrd)   rdata = vcrd_q   & VCRD_RMASK;
        if (sel_vcrwdt) rdata = vcrwdt_q & VCRWDT_RMASK;
    end

    // Source vectors in INTC_SRC_e order (bit/element 0 = DIVU).
    logic [NUM_SRC-1:0]            src_req;
    logic [NUM_SRC-1:0][3:0]       src_lvl;
    logic [NUM_SRC-1:0][VEC_W-1:0] src_vec;
    logic [3:0]                    win_lvl;
    logic [VEC_W-1:0]              win_vec;
    logic [3:0]                    win_idx;

    assign src_req = {FRT_OVI, FRT_OCIB, FRT_OCIA, FRT_ICI,
                      SCI_TEI, SCI_TXI, SCI_RXI, SCI_ERI,
                      BSC_CMI, WDT_ITI, DMA1_IRQ, DMA0_IRQ, DIVU_IRQ};
    assign src_lvl = {iprb_q.frt, iprb_q.frt, iprb_q.frt, iprb_q.frt,
                      iprb_q.sci, iprb_q.sci, iprb_q.sci, iprb_q.sci,
                      ipra_q.wdt, ipra_q.wdt, ipra_q.dmac, ipra_q.dmac, ipra_q.divu};
    assign src_vec = {VEC_W'(vcrd_q.ovi), VEC_W'(vcrc_q.oci), VEC_W'(vcrc_q.oci), VEC_W'(vcrc_q.ici),
                      VEC_W'(vcrb_q.tei), VEC_W'(vcrb_q.txi), VEC_W'(vcra_q.rxi), VEC_W'(vcra_q.eri),
                      VEC_W'(vcrwdt_q.cmi), VEC_W'(vcrwdt_q.iti),
                      VEC_W'(DMA1_VEC), VEC_W'(DMA0_VEC), VEC_W'(DIVU_VEC)};

    sh7604_intc_prio_enc #(.VEC_W(VEC_W)) u_prio_enc (
        .req_i (src_req),
        .lvl_i (src_lvl),
        .vec_i (src_vec),
        .lvl_o (win_lvl),
        .vec_o (win_vec),
        .idx_o (win_idx)
    );

`ifdef INTC_ACK_SRC_EN
    logic [3:0] int_src_q;
    logic [3:0] ack_src_q;
    assign ACK_SRC = ack_src_q;
`else
    logic unused_idx;
    assign unused_idx = ^win_idx;
`endif

    // Registers commit on CE_R; ACK samples the already-registered winner so
    // the CPU gets exactly the vector it saw with INT_REQ.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ipra_q    <= IPRA_INIT;
            iprb_q    <= IPRB_INIT;
            vcra_q    <= VCRA_INIT;
            vcrb_q    <= VCRB_INIT;
            vcrc_q    <= VCRC_INIT;
            vcrd_q    <= VCRD_INIT;
            vcrwdt_q  <= VCRWDT_INIT;
            int_req_q <= 1'b0;
            int_lvl_q <= '0;
            int_vec_q <= '0;
            ack_vec_q <= '0;
`ifdef INTC_ACK_SRC_EN
            int_src_q <= '0;
            ack_src_q <= '0;
`endif
        end else if (CE_R && !RES_N) begin
            ipra_q    <= IPRA_INIT;
            iprb_q    <= IPRB_INIT;
            vcra_q    <= VCRA_INIT;
            vcrb_q    <= VCRB_INIT;
            vcrc_q    <= VCRC_INIT;
            vcrd_q    <= VCRD_INIT;
            vcrwdt_q  <= VCRWDT_INIT;
            int_req_q <= 1'b0;
            int_lvl_q <= '0;
            int_vec_q <= '0;
            ack_vec_q <= '0;
`ifdef INTC_ACK_SRC_EN
            int_src_q <= '0;
            ack_src_q <= '0;
`endif
        end else begin
            ipra_q   <= ipra_d;
            iprb_q   <= iprb_d;
            vcra_q   <= vcra_d;
            vcrb_q   <= vcrb_d;
            vcrc_q   <= vcrc_d;
            vcrd_q   <= vcrd_d;
            vcrwdt_q <= vcrwdt_d;
            if (CE_R && EN) begin
                int_req_q <= (win_lvl != 4'd0);
                int_lvl_q <= win_lvl;
                int_vec_q <= win_vec;
`ifdef INTC_ACK_SRC_EN
                int_src_q <= win_idx;
`endif
                if (INT_ACK) begin
                    ack_vec_q <= int_vec_q;
`ifdef INTC_ACK_SRC_EN
                    ack_src_q <= int_src_q;
`endif
                end
            end
        end
    end

    // Read data is captured on the falling phase; unselected reads return 0.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            reg_do_q <= '0;
        end else if (CE_R && !RES_N) begin
            reg_do_q <= '0;
        end else if (CE_F && EN) begin
            reg_do_q <= (IBUS.REQ && !IBUS.WE) ? rdata : 16'h0000;
        end
    end

    assign INT_REQ = int_req_q;
    assign INT_LVL = int_lvl_q;
    assign INT_VEC = int_vec_q;
    assign ACK_VEC = ack_vec_q;

endmodule
